// File: rtl/stopwatch_seg_driver.sv
// Stopwatch display driver: converts a seconds count to MM:SS BCD with a multi-cycle
// subtractor, then scans the four digits onto a common-anode 7-segment display.
module stopwatch_seg_driver #(
    parameter int unsigned SCAN_BITS  = 18,
    parameter int unsigned BLINK_BITS = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] seconds,
    input  logic        adj,
    input  logic [1:0]  sel,
    output logic [15:0] bcd,
    output logic        busy,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);
    localparam logic [12:0] MaxSec = 13'd6039;

    typedef enum logic [2:0] {StIdle, StMin, StMten, StSten, StCommit} state_e;

    state_e      state_q, state_d;
    logic [12:0] work_q, work_d;
    logic [12:0] target_q, target_d;
    logic [12:0] last_q, last_d;
    logic [6:0]  min_q, min_d;
    logic [3:0]  mt_q, mt_d;
    logic [3:0]  st_q, st_d;
    logic        first_q, first_d;
    logic [15:0] bcd_q, bcd_d;
    logic        busy_q, busy_d;
    logic [12:0] clamped;

    assign clamped = (seconds > MaxSec) ? MaxSec : seconds;

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        target_d = target_q;
        last_d   = last_q;
        min_d    = min_q;
        mt_d     = mt_q;
        st_d     = st_q;
        first_d  = first_q;
        bcd_d    = bcd_q;
        busy_d   = busy_q;
        unique case (state_q)
            StIdle: begin
                if (first_q || (clamped != last_q)) begin
                    work_d   = clamped;
                    target_d = clamped;
                    min_d    = 7'd0;
                    mt_d     = 4'd0;
                    st_d     = 4'd0;
                    first_d  = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = StMin;
                end
            end
            StMin: begin
                // Minutes saturate at 99 so the top count 6039 shows as 99:99.
                if ((work_q >= 13'd60) && (min_q < 7'd99)) begin
                    work_d = work_q - 13'd60;
                    min_d  = min_q + 7'd1;
                end else begin
                    state_d = StMten;
                end
            end
            StMten: begin
                if (min_q >= 7'd10) begin
                    min_d = min_q - 7'd10;
                    mt_d  = mt_q + 4'd1;
                end else begin
                    state_d = StSten;
                end
            end
            StSten: begin
                if (work_q >= 13'd10) begin
                    work_d = work_q - 13'd10;
                    st_d   = st_q + 4'd1;
                end else begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                bcd_d   = {mt_q, min_q[3:0], st_q, work_q[3:0]};
                last_d  = target_q;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            work_q   <= '0;
            target_q <= '0;
            last_q   <= '0;
            min_q    <= '0;
            mt_q     <= '0;
            st_q     <= '0;
            first_q  <= 1'b1;
            bcd_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            target_q <= target_d;
            last_q   <= last_d;
            min_q    <= min_d;
            mt_q     <= mt_d;
            st_q     <= st_d;
            first_q  <= first_d;
            bcd_q    <= bcd_d;
            busy_q   <= busy_d;
        end
    end

    logic [SCAN_BITS-1:0]  scan_q;
    logic [BLINK_BITS-1:0] blink_q;
    logic [1:0]            idx_q;
    logic [3:0]            digit;
    logic [6:0]            pattern;
    logic                  blank;
    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [3:0]            an_q;

    assign digit = bcd_q[{idx_q, 2'b00} +: 4];
    assign blank = adj && (idx_q == sel) && blink_q[BLINK_BITS-1];

    always_comb begin
        pattern = 7'h7F;
        case (digit)
            4'd0: pattern = 7'h40;
            4'd1: pattern = 7'h79;
            4'd2: pattern = 7'h24;
            4'd3: pattern = 7'h30;
            4'd4: pattern = 7'h19;
            4'd5: pattern = 7'h12;
            4'd6: pattern = 7'h02;
            4'd7: pattern = 7'h78;
            4'd8: pattern = 7'h00;
            4'd9: pattern = 7'h10;
            default: pattern = 7'h7F;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q  <= '0;
            blink_q <= '0;
            idx_q   <= 2'd0;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            an_q    <= 4'hF;
        end else begin
            scan_q  <= scan_q + 1'b1;
            blink_q <= blink_q + 1'b1;
            if (&scan_q) begin
                idx_q <= idx_q + 2'd1;
            end
            seg_q <= pattern;
            dp_q  <= (idx_q != 2'd2);
            an_q  <= blank ? 4'hF : ~(4'b0001 << idx_q);
        end
    end

    assign bcd  = bcd_q;
    assign busy = busy_q;
    assign seg  = seg_q;
    assign dp   = dp_q;
    assign an   = an_q;

endmodule

// File: tb/tb_stopwatch_seg_driver.sv
// Scoreboard bench for stopwatch_seg_driver: expected BCD commits are queued at stimulus time
// and checked by a monitor on each busy falling edge; display scanning is checked per cycle.
module tb_stopwatch_seg_driver;
    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] seconds;
    logic        adj;
    logic [1:0]  sel;
    logic [15:0] bcd;
    logic        busy;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [15:0] exp_q[$];
    bit prev_busy = 1'b0;

    stopwatch_seg_driver #(
        .SCAN_BITS  (2),
        .BLINK_BITS (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .seconds (seconds),
        .adj     (adj),
        .sel     (sel),
        .bcd     (bcd),
        .busy    (busy),
        .seg     (seg),
        .dp      (dp),
        .an      (an)
    );

    always #5 clk = ~clk;

    // Edges since reset release; scan and blink counters both start from zero.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Monitor: every busy 1->0 outside reset is a commit and must match the queue head.
    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !busy) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL commit_unexpected: bcd=%h required=no commit", bcd);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (bcd !== e) begin
                        bad++;
                        $display("FAIL commit_bcd: bcd=%h required=%h", bcd, e);
                    end
                end
            end
            prev_busy = busy;
        end
    end

    function automatic logic [6:0] pat(input logic [3:0] d);
        case (d)
            4'd0: pat = 7'h40;
            4'd1: pat = 7'h79;
            4'd2: pat = 7'h24;
            4'd3: pat = 7'h30;
            4'd4: pat = 7'h19;
            4'd5: pat = 7'h12;
            4'd6: pat = 7'h02;
            4'd7: pat = 7'h78;
            4'd8: pat = 7'h00;
            4'd9: pat = 7'h10;
            default: pat = 7'h7F;
        endcase
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%h required=%h", nm, act, req);
        end
    endtask

    task automatic apply(input logic [12:0] s, input logic [15:0] e);
        @(negedge clk);
        seconds = s;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 400) begin
            bad++;
            $display("FAIL %s: still busy after %0d cycles, pending=%0d required=0", nm, n,
                     exp_q.size());
        end
    endtask

    task automatic wait_busy(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 50);
        total++;
        if (!busy) begin
            bad++;
            $display("FAIL %s: busy=%0b required=1", nm, busy);
        end
    endtask

    // Outputs sampled now reflect counter state after cyc-1 edges.
    task automatic check_display(input int n, input logic [15:0] eb, input string nm);
        for (int i = 0; i < n; i++) begin
            int c;
            int idx;
            bit bl;
            logic [3:0] ea;
            logic [3:0] dg;
            @(negedge clk);
            c   = cyc - 1;
            idx = (c / 4) % 4;
            bl  = (c % 16) >= 8;
            ea  = (adj && idx == int'(sel) && bl) ? 4'hF : ~(4'b0001 << idx);
            dg  = eb[idx*4 +: 4];
            check({nm, "_an"}, {12'h0, an}, {12'h0, ea});
            check({nm, "_seg"}, {9'h0, seg}, {9'h0, pat(dg)});
            check({nm, "_dp"}, {15'h0, dp}, {15'h0, (idx != 2)});
        end
    endtask

    logic [12:0] vsec [4] = '{13'd59, 13'd60, 13'd600, 13'd5999};
    logic [15:0] vbcd [4] = '{16'h0059, 16'h0100, 16'h1000, 16'h9959};

    initial begin
        rst     = 1'b1;
        seconds = 13'd0;
        adj     = 1'b0;
        sel     = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_an", {12'h0, an}, 16'h000F);
        check("rst_seg", {9'h0, seg}, 16'h007F);
        check("rst_dp", {15'h0, dp}, 16'h0001);
        check("rst_busy", {15'h0, busy}, 16'h0000);
        check("rst_bcd", bcd, 16'h0000);
        exp_q.push_back(16'h0000);
        rst = 1'b0;
        wait_idle("init_conv");
        check_display(32, 16'h0000, "scan0");

        apply(13'd8191, 16'h9999);
        wait_idle("clamp_8191");
        check_display(16, 16'h9999, "scan9999");

        // 6039 clamps to the same value as 8191, so no new conversion may start.
        begin
            bit seen = 1'b0;
            @(negedge clk);
            seconds = 13'd6039;
            repeat (40) begin
                @(negedge clk);
                if (busy) seen = 1'b1;
            end
            check("no_reconv_busy", {15'h0, seen}, 16'h0000);
            check("no_reconv_bcd", bcd, 16'h9999);
        end

        for (int i = 0; i < 4; i++) begin
            apply(vsec[i], vbcd[i]);
            wait_idle("vec");
        end
        check_display(16, 16'h9959, "scan9959");

        apply(13'd125, 16'h0205);
        wait_busy("busy_125");
        seconds = 13'd3600;
        exp_q.push_back(16'h6000);
        wait_idle("restart_3600");
        check_display(16, 16'h6000, "scan6000");

        adj = 1'b1;
        sel = 2'd1;
        apply(13'd754, 16'h1234);
        wait_idle("conv_754");
        check_display(64, 16'h1234, "blink");
        adj = 1'b0;
        sel = 2'd0;

        apply(13'd3000, 16'h5000);
        wait_busy("busy_3000");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", {15'h0, busy}, 16'h0000);
        check("midrst_bcd", bcd, 16'h0000);
        check("midrst_an", {12'h0, an}, 16'h000F);
        rst = 1'b0;
        wait_idle("after_midrst");
        check_display(16, 16'h5000, "scan5000");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
